xorlfsr_session_ctrl: RTL and testbench
=======================================

Name: xorlfsr_session_ctrl

Overview:
- Sequences the 8-lane XOR-LFSR stream core through one cipher session: seed load, seed commit, warm-up, then a length-bounded payload stream.
- Sits between a byte-wide host valid/ready interface and the core's strobes (seeddata, setseed, streamdata, datain, dataout).
- Rejects seeds containing an all-zero 16-bit lane, which would lock that LFSR.

Parameters:
- LEN_W, 16, width of the payload byte count.
- WARMUP, 32, number of keystream cycles discarded after seed commit; 0 is legal.
- SEED_BYTES, 16, seed bytes per session (8 lanes x 2 bytes); fixed by the core.

Ports:
- dataclk  in  1  single clock for the controller and the core.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle request to begin a session; honoured only in IDLE.
- cmd_len  in  LEN_W  payload byte count; sampled when cmd_start is taken.
- abort  in  1  returns the block to IDLE from any state.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte: seed bytes first, then payload.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_valid  out  1  ciphertext/plaintext byte valid.
- out_data  out  8  result byte, passed through from core_dataout.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a session completes normally.
- seed_err  out  1  sticky flag; cleared when the next cmd_start is taken.
- core_datain  out  8  byte driven to the core.
- core_seeddata  out  1  shifts core_datain into the core seed buffer.
- core_setseed  out  1  commits the seed buffer into the LFSRs.
- core_streamdata  out  1  core registers core_datain XOR keystream.
- core_dataout  in  8  core result, valid 1 cycle after core_streamdata.

Behaviour:
- Reset: state=IDLE. in_ready, out_valid, busy, done, seed_err, core_seeddata, core_setseed and core_streamdata are 0. core_datain is 0x00. Counters are 0.
- States: IDLE, SEED, ARM, WARM, STREAM, FIN.
- IDLE: in_ready=0. On cmd_start: latch cmd_len, clear seed_err, go to SEED.
- SEED: in_ready=1. On each accepted byte, pulse core_seeddata with core_datain=in_data and increment seed_cnt (0..15).
  - Bytes 2k and 2k+1 form lane pair k.
  - If both bytes of any pair are 0x00, set an internal zero_hit flag.
  - After byte 15: if zero_hit, set seed_err, stay in SEED for no further cycles, go to IDLE with no setseed and no done pulse. Otherwise go to ARM.
- ARM: core_setseed=1 for exactly 1 cycle; in_ready=0. Then go to WARM.
- WARM: in_ready=0. Count WARMUP cycles; the core keystream advances every cycle. Then:
  - latched len == 0: go to FIN;
  - otherwise: go to STREAM.
  - WARMUP=0 means ARM is followed directly by that decision.
- STREAM: in_ready=1. On each accepted byte, pulse core_streamdata with core_datain=in_data and decrement remaining. When the last byte is accepted, go to FIN.
- Keystream rule: the core keystream advances every cycle after ARM, stalled or not. A cycle with in_valid low consumes keystream. Peer endpoints must reproduce the same stall pattern to decrypt.
- Output: out_valid is core_streamdata delayed by one register. out_data = core_dataout. Latency is 1 cycle from acceptance. There is no output backpressure.
- FIN: 1 cycle, which lets the final out_valid issue. Pulse done, then go to IDLE.
- core_datain = in_data in SEED and STREAM, else 0x00. Strobes are never asserted together.
- Abort: takes priority over all transitions, including cmd_start in IDLE.
  - Next state is IDLE; in_ready is forced 0 in the abort cycle.
  - A byte accepted in the previous cycle still produces its out_valid.
  - No done pulse. seed_err is unchanged. Partial seed data is left in the core and is overwritten by the next session.
- cmd_start while busy: ignored.
- Reset mid-operation: immediate return to reset values. The core has no reset; the next session reloads all 16 seed bytes.
- Counters: seed_cnt is 4 bits; remaining is LEN_W bits; the warm-up counter is clog2(WARMUP+1) bits. No wrap occurs within legal use.

Decomposition:
- Shared package xorlfsr_pkg holds:
  - the state enum;
  - SEED_BYTES=16;
  - LANES=8;
  - LANE_BYTES=2.
- One natural sub-module, xorlfsr_seed_checker: byte counter, pair assembly and zero-lane flag; outputs seed_last and zero_hit.

Test Plan:
- Seed 0x01..0x10, len=4, WARMUP=0, bytes 0xAA,0x55,0x00,0xFF streamed back-to-back -> exactly 16 core_seeddata pulses, 1 core_setseed pulse, 4 out_valid each 1 cycle after acceptance, out_data matches the golden LFSR model, done pulses once, busy falls after FIN.
- Seed with bytes 6,7 = 0x00,0x00 -> seed_err=1 after byte 15, no core_setseed, no done, in IDLE; next cmd_start clears seed_err.
- len=3 with in_valid low for 2 cycles between bytes 1 and 2 -> 3 out_valid; byte 2 uses keystream index offset by 2 relative to the no-stall case.
- WARMUP=32, len=0 -> core_setseed, 32 WARM cycles, FIN, done; zero out_valid; in_ready never high after SEED.
- abort asserted at seed byte 9 -> IDLE next cycle, no setseed; new session with 16 fresh bytes decrypts correctly.
- rst_n low mid-STREAM for 1 cycle -> all outputs 0 asynchronously, state IDLE; cmd_start with the same seed reproduces byte 0 keystream.

Source files
------------

// File: rtl/xorlfsr_pkg.sv
// Shared types and constants for the XOR-LFSR session controller.
// The seed geometry is fixed by the 8-lane, 16-bit-per-lane stream core.
package xorlfsr_pkg;

  localparam int LANES      = 8;
  localparam int LANE_BYTES = 2;
  localparam int SEED_BYTES = LANES * LANE_BYTES;
  localparam int SEED_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_ARM,
    ST_WARM,
    ST_STREAM,
    ST_FIN
  } state_e;

endpackage

// File: rtl/xorlfsr_seed_checker.sv
// Counts seed bytes, pairs them into 16-bit lanes and flags any all-zero lane.
// zero_hit_o already includes the pair completed by the byte being accepted.
module xorlfsr_seed_checker
  import xorlfsr_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       byte_vld_i,
  input  logic [7:0] byte_i,
  output logic       seed_last_o,
  output logic       zero_hit_o
);

  logic [SEED_CNT_W-1:0] seed_cnt_q, seed_cnt_d;
  logic                  hi_zero_q, hi_zero_d;
  logic                  zero_q, zero_d;
  logic                  pair_zero;

  // An odd count means this byte closes the lane whose first byte is already held.
  assign pair_zero   = byte_vld_i && seed_cnt_q[0] && hi_zero_q && (byte_i == 8'h00);
  assign seed_last_o = byte_vld_i && (seed_cnt_q == SEED_CNT_W'(SEED_BYTES - 1));
  assign zero_hit_o  = zero_q || pair_zero;

  always_comb begin
    seed_cnt_d = seed_cnt_q;
    hi_zero_d  = hi_zero_q;
    zero_d     = zero_q;
    if (clear_i) begin
      seed_cnt_d = '0;
      hi_zero_d  = 1'b0;
      zero_d     = 1'b0;
    end else if (byte_vld_i) begin
      seed_cnt_d = seed_cnt_q + 1'b1;
      zero_d     = zero_q || pair_zero;
      if (!seed_cnt_q[0]) begin
        hi_zero_d = (byte_i == 8'h00);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seed_cnt_q <= '0;
      hi_zero_q  <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      seed_cnt_q <= seed_cnt_d;
      hi_zero_q  <= hi_zero_d;
      zero_q     <= zero_d;
    end
  end

endmodule

// File: rtl/xorlfsr_session_ctrl.sv
// Session sequencer for the XOR-LFSR stream core: seed load, commit, warm-up
// and a length-bounded payload stream behind a byte-wide valid/ready port.
module xorlfsr_session_ctrl
  import xorlfsr_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int WARMUP = 32
) (
  input  logic             dataclk,
  input  logic             rst_n,
  input  logic             cmd_start,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             done,
  output logic             seed_err,
  output logic [7:0]       core_datain,
  output logic             core_seeddata,
  output logic             core_setseed,
  output logic             core_streamdata,
  input  logic [7:0]       core_dataout
);

  localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic              seed_err_q, seed_err_d;
  logic              out_valid_q;

  logic   start_take, seed_acc, strm_acc;
  logic   seed_last, zero_hit;
  state_e post_warm;

  assign start_take = (state_q == ST_IDLE) && cmd_start && !abort;
  assign seed_acc   = (state_q == ST_SEED) && in_valid && !abort;
  assign strm_acc   = (state_q == ST_STREAM) && in_valid && !abort;
  assign post_warm  = (rem_q == '0) ? ST_FIN : ST_STREAM;

  xorlfsr_seed_checker u_seed_checker (
    .clk_i       (dataclk),
    .rst_ni      (rst_n),
    .clear_i     (start_take),
    .byte_vld_i  (seed_acc),
    .byte_i      (in_data),
    .seed_last_o (seed_last),
    .zero_hit_o  (zero_hit)
  );

  always_ff @(posedge dataclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      warm_q      <= '0;
      seed_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      warm_q      <= warm_d;
      seed_err_q  <= seed_err_d;
      out_valid_q <= strm_acc;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    warm_d     = warm_q;
    seed_err_d = seed_err_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_start) begin
            state_d    = ST_SEED;
            rem_d      = cmd_len;
            seed_err_d = 1'b0;
          end
        end
        ST_SEED: begin
          if (seed_last) begin
            if (zero_hit) begin
              seed_err_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_ARM;
            end
          end
        end
        ST_ARM: begin
          warm_d  = '0;
          state_d = (WARMUP == 0) ? post_warm : ST_WARM;
        end
        ST_WARM: begin
          warm_d = warm_q + 1'b1;
          if (warm_q == WARM_LAST) begin
            state_d = post_warm;
          end
        end
        ST_STREAM: begin
          if (in_valid) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
              state_d = ST_FIN;
            end
          end
        end
        ST_FIN: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Strobes are mutually exclusive by construction: each belongs to one state.
  always_comb begin
    in_ready        = !abort && ((state_q == ST_SEED) || (state_q == ST_STREAM));
    core_seeddata   = seed_acc;
    core_setseed    = (state_q == ST_ARM) && !abort;
    core_streamdata = strm_acc;
    core_datain     = ((state_q == ST_SEED) || (state_q == ST_STREAM)) ? in_data : 8'h00;
    busy            = (state_q != ST_IDLE);
    done            = (state_q == ST_FIN) && !abort;
    seed_err        = seed_err_q;
    out_valid       = out_valid_q;
    out_data        = core_dataout;
  end

endmodule

// File: tb/tb_xorlfsr_session_ctrl.sv
// Randomized session bench: two controllers (WARMUP=0 and WARMUP=32) drive a
// behavioural 8-lane LFSR core; results are checked against a keystream-by-index model.
module tb_xorlfsr_session_ctrl;

  logic dataclk = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;

  logic [1:0]       cmd_start, abort, in_valid, in_ready, out_valid, busy, done, seed_err;
  logic [1:0]       core_seeddata, core_setseed, core_streamdata;
  logic [1:0][15:0] cmd_len;
  logic [1:0][7:0]  in_data, out_data, core_datain, core_dataout;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      xorlfsr_session_ctrl #(.LEN_W(16), .WARMUP((gi == 0) ? 0 : 32)) u_dut (
        .dataclk         (dataclk),
        .rst_n           (rst_n),
        .cmd_start       (cmd_start[gi]),
        .cmd_len         (cmd_len[gi]),
        .abort           (abort[gi]),
        .in_valid        (in_valid[gi]),
        .in_data         (in_data[gi]),
        .in_ready        (in_ready[gi]),
        .out_valid       (out_valid[gi]),
        .out_data        (out_data[gi]),
        .busy            (busy[gi]),
        .done            (done[gi]),
        .seed_err        (seed_err[gi]),
        .core_datain     (core_datain[gi]),
        .core_seeddata   (core_seeddata[gi]),
        .core_setseed    (core_setseed[gi]),
        .core_streamdata (core_streamdata[gi]),
        .core_dataout    (core_dataout[gi])
      );
    end
  endgenerate

  initial forever #5 dataclk = ~dataclk;
  always @(posedge dataclk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [127:0] step_all(input logic [127:0] l);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = lane_step(l[16*k +: 16]);
    return r;
  endfunction

  function automatic logic [7:0] ks_of(input logic [127:0] l);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < 8; k++) x ^= l[16*k +: 8];
    return x;
  endfunction

  // Keystream byte n cycles after the seed is committed, computed lane by lane.
  function automatic logic [7:0] ks_at(input logic [127:0] seed, input int n);
    logic [15:0] lane;
    logic [7:0]  x;
    x = 8'h00;
    for (int k = 0; k < 8; k++) begin
      lane = seed[16*k +: 16];
      for (int j = 0; j < n; j++) lane = lane_step(lane);
      x ^= lane[7:0];
    end
    return x;
  endfunction

  function automatic logic [127:0] rand_seed();
    logic [127:0] s;
    for (int k = 0; k < 8; k++) s[16*k +: 16] = 16'($urandom_range(1, 65535));
    return s;
  endfunction

  // Behavioural core: seed shift buffer, 8 free-running lanes, registered XOR.
  logic [1:0][127:0] sbuf, lanes;
  initial begin
    sbuf         = '0;
    lanes        = '0;
    core_dataout = '0;
  end
  always @(posedge dataclk) begin
    for (int i = 0; i < 2; i++) begin
      if (core_seeddata[i]) sbuf[i] <= {sbuf[i][119:0], core_datain[i]};
      if (core_setseed[i]) lanes[i] <= sbuf[i];
      else                 lanes[i] <= step_all(lanes[i]);
      if (core_streamdata[i]) core_dataout[i] <= core_datain[i] ^ ks_of(lanes[i]);
    end
  end

  typedef struct packed {
    int         inst;
    int         at;
    logic [7:0] val;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_seed[2], n_set[2], n_done[2], n_ov[2], set_edge[2];
  initial for (int i = 0; i < 2; i++) begin
    n_seed[i] = 0; n_set[i] = 0; n_done[i] = 0; n_ov[i] = 0; set_edge[i] = 0;
  end

  always @(negedge dataclk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (core_seeddata[i] || core_setseed[i] || core_streamdata[i])
          check_eq("strobe_excl", 32'($countones({core_seeddata[i], core_setseed[i], core_streamdata[i]})), 1);
        if (core_seeddata[i]) n_seed[i]++;
        if (core_setseed[i]) begin
          n_set[i]++;
          set_edge[i] = cyc + 1;
        end
        if (done[i]) n_done[i]++;
        if (out_valid[i]) begin
          n_ov[i]++;
          if (exp_q.size() == 0) begin
            check_eq("ov_unexpected", out_valid[i], 0);
          end else begin
            mon_e = exp_q.pop_front();
            check_eq("ov_inst", i, mon_e.inst);
            check_eq("ov_latency", cyc, mon_e.at);
            check_eq("out_data", out_data[i], mon_e.val);
          end
        end
      end
    end
  end

  // Drives a byte from a negedge; returns before the accepting edge with its index.
  task automatic send_byte(input int d, input logic [7:0] b, output int a);
    in_valid[d] = 1'b1;
    in_data[d]  = b;
    a = -1;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (in_ready[d]) begin
        a = cyc + 1;
        break;
      end
      @(negedge dataclk);
    end
    if (a < 0) check_eq("ready_timeout", in_ready[d], 1);
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    check_eq({tag, "_in_ready"}, in_ready[d], 0);
    check_eq({tag, "_out_valid"}, out_valid[d], 0);
    check_eq({tag, "_busy"}, busy[d], 0);
    check_eq({tag, "_done"}, done[d], 0);
    check_eq({tag, "_strobes"}, {core_seeddata[d], core_setseed[d], core_streamdata[d]}, 0);
    check_eq({tag, "_datain"}, core_datain[d], 0);
  endtask

  // cut_kind: 0 none, 1 abort before stream byte cut_at, 2 reset before stream byte cut_at
  task automatic run_session(input int d, input logic [127:0] seed, input int len,
                             input bit fixed, input int stall_at, input int stall_n,
                             input int cut_at, input int cut_kind, input bit expect_err);
    int a, prev_a, s_edge, t_start, w, fin_exp, rdy_seen;
    int seed0, set0, done0, ov0;
    logic [7:0] b;
    logic [7:0] pat [4];
    pat = '{8'hAA, 8'h55, 8'h00, 8'hFF};
    w = (d == 0) ? 0 : 32;
    seed0 = n_seed[d]; set0 = n_set[d]; done0 = n_done[d]; ov0 = n_ov[d];
    $display("session inst=%0d len=%0d seed=%032h stall=%0d/%0d cut=%0d/%0d err=%0d",
             d, len, seed, stall_at, stall_n, cut_at, cut_kind, expect_err);

    cmd_start[d] = 1'b1;
    cmd_len[d]   = 16'(len);
    t_start      = cyc + 1;
    @(negedge dataclk);
    cmd_start[d] = 1'b0;
    check_eq("busy_after_start", busy[d], 1);
    check_eq("seed_err_cleared", seed_err[d], 0);

    s_edge = 0;
    for (int i = 0; i < 16; i++) begin
      send_byte(d, seed[127-8*i -: 8], a);
      if (i == 0) check_eq("seed_first_edge", a, t_start + 1);
      s_edge = a;
      @(negedge dataclk);
    end
    in_valid[d] = 1'b0;
    check_eq("seeddata_count", n_seed[d] - seed0, 16);

    if (expect_err) begin
      check_eq("seed_err_set", seed_err[d], 1);
      check_eq("seed_err_idle", busy[d], 0);
      repeat (3) @(negedge dataclk);
      check_eq("seed_err_no_setseed", n_set[d] - set0, 0);
      check_eq("seed_err_no_done", n_done[d] - done0, 0);
      check_eq("seed_err_sticky", seed_err[d], 1);
      return;
    end

    prev_a = s_edge;
    for (int i = 0; i < len; i++) begin
      if (i == cut_at && cut_kind == 1) begin
        abort[d] = 1'b1;
        in_valid[d] = 1'b1;
        #1;
        check_eq("abort_in_ready", in_ready[d], 0);
        check_eq("abort_no_stream", core_streamdata[d], 0);
        @(negedge dataclk);
        abort[d] = 1'b0;
        in_valid[d] = 1'b0;
        check_eq("abort_idle", busy[d], 0);
        check_eq("abort_ov_count", n_ov[d] - ov0, cut_at);
        check_eq("abort_no_done", n_done[d] - done0, 0);
        check_eq("abort_drained", exp_q.size(), 0);
        return;
      end
      if (i == cut_at && cut_kind == 2) begin
        in_valid[d] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs(d, "rst_mid");
        check_eq("rst_mid_seed_err", seed_err[d], 0);
        @(negedge dataclk);
        #2 rst_n = 1'b1;
        in_valid[d] = 1'b0;
        @(negedge dataclk);
        check_eq("rst_ov_count", n_ov[d] - ov0, cut_at);
        check_eq("rst_drained", exp_q.size(), 0);
        check_eq("rst_idle", busy[d], 0);
        return;
      end
      if (i == stall_at) begin
        in_valid[d] = 1'b0;
        repeat (stall_n) @(negedge dataclk);
      end
      b = fixed ? pat[i % 4] : 8'($urandom);
      send_byte(d, b, a);
      if (i == 0) check_eq("first_stream_edge", a, s_edge + 2 + w);
      if (i == stall_at) check_eq("stall_edge", a, prev_a + 1 + stall_n);
      exp_q.push_back('{d, a, b ^ ks_at(seed, a - s_edge - 2)});
      prev_a = a;
      @(negedge dataclk);
    end
    in_valid[d] = 1'b0;

    fin_exp = (len == 0) ? (s_edge + 1 + w) : prev_a;
    rdy_seen = 0;
    for (int k = 0; k < 200 && !done[d]; k++) begin
      if (in_ready[d]) rdy_seen++;
      @(negedge dataclk);
    end
    check_eq("done_seen", done[d], 1);
    check_eq("done_edge", cyc, fin_exp);
    check_eq("no_ready_before_fin", rdy_seen, 0);
    @(negedge dataclk);
    check_eq("busy_fall", busy[d], 0);
    check_eq("setseed_once", n_set[d] - set0, 1);
    check_eq("setseed_edge", set_edge[d], s_edge + 1);
    check_eq("done_once", n_done[d] - done0, 1);
    check_eq("ov_count", n_ov[d] - ov0, len);
    check_eq("ov_drained", exp_q.size(), 0);
  endtask

  logic [127:0] seed_a, seed_b;
  int           a_tmp, seed0, set0;

  initial begin
    cmd_start = '0; abort = '0; in_valid = '0; cmd_len = '0; in_data = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_idle_outputs(d, "reset");
      check_eq("reset_seed_err", seed_err[d], 0);
    end
    repeat (2) @(negedge dataclk);
    rst_n = 1'b1;
    @(negedge dataclk);

    seed_a = 128'h0102030405060708090A0B0C0D0E0F10;
    run_session(0, seed_a, 4, 1'b1, -1, 0, -1, 0, 1'b0);

    // Lane 3 (bytes 6,7) all zero, then lane 7 (bytes 14,15) all zero.
    run_session(0, 128'h0102030405060000090A0B0C0D0E0F10, 2, 1'b0, -1, 0, -1, 0, 1'b1);
    run_session(0, 128'h0102030405060708090A0B0C0D0E0000, 2, 1'b0, -1, 0, -1, 0, 1'b1);
    // Half-zero lane and zeros straddling a lane boundary are legal.
    run_session(0, 128'h0102030405060001090A0B0C0D0E0F10, 2, 1'b0, -1, 0, -1, 0, 1'b0);
    run_session(0, 128'h0102030405060700000A0B0C0D0E0F10, 2, 1'b0, -1, 0, -1, 0, 1'b0);

    run_session(0, rand_seed(), 3, 1'b0, 2, 2, -1, 0, 1'b0);
    run_session(1, rand_seed(), 0, 1'b0, -1, 0, -1, 0, 1'b0);
    run_session(1, rand_seed(), 3, 1'b0, -1, 0, -1, 0, 1'b0);

    // Abort on seed byte 9, then a full fresh session.
    $display("session inst=0 abort at seed byte 9");
    seed0 = n_seed[0]; set0 = n_set[0];
    cmd_start[0] = 1'b1; cmd_len[0] = 16'd5;
    @(negedge dataclk);
    cmd_start[0] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send_byte(0, 8'($urandom), a_tmp);
      @(negedge dataclk);
    end
    abort[0] = 1'b1;
    in_valid[0] = 1'b1;
    #1;
    check_eq("seed_abort_in_ready", in_ready[0], 0);
    check_eq("seed_abort_no_shift", core_seeddata[0], 0);
    @(negedge dataclk);
    abort[0] = 1'b0;
    in_valid[0] = 1'b0;
    check_eq("seed_abort_idle", busy[0], 0);
    check_eq("seed_abort_bytes", n_seed[0] - seed0, 9);
    repeat (3) @(negedge dataclk);
    check_eq("seed_abort_no_setseed", n_set[0] - set0, 0);
    run_session(0, rand_seed(), 4, 1'b0, -1, 0, -1, 0, 1'b0);

    // Abort wins over cmd_start in IDLE.
    cmd_start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge dataclk);
    cmd_start[0] = 1'b0; abort[0] = 1'b0;
    check_eq("abort_beats_start", busy[0], 0);

    run_session(0, rand_seed(), 5, 1'b0, -1, 0, 2, 1, 1'b0);

    seed_b = rand_seed();
    run_session(0, seed_b, 6, 1'b0, -1, 0, 2, 2, 1'b0);
    run_session(0, seed_b, 2, 1'b0, -1, 0, -1, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int d, len, st, sn;
      d   = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 6));
      st  = int'($urandom_range(1, 6));
      sn  = int'($urandom_range(0, 3));
      run_session(d, rand_seed(), len, 1'b0, st, sn, -1, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
